mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 135 +++++++++++++
 tb/tb_mul_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier with optional two's-complement operands.
// One multiply takes WIDTH shift-add steps, one sign-fix step and one done cycle.
module mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } stateT;

   stateT                state;
   stateT                nextState;
   logic [2*WIDTH-1:0]   accum;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     absA;
   logic [WIDTH-1:0]     absB;
   logic [CW-1:0]        count;
   logic                 negResult;
   logic                 lastStep;

   // Operand magnitudes. A negative signed operand is negated; the most
   // negative value negates to itself, which read as unsigned is exactly
   // 2^(WIDTH-1), so no special case is needed. The final product is the
   // accumulator, negated when the operand signs differed.
   always_comb begin
      absA     = (is_signed && a[WIDTH-1]) ? -a : a;
      absB     = (is_signed && b[WIDTH-1]) ? -b : b;
      lastStep = (count == CW'(WIDTH - 1));
      product  = negResult ? -accum : accum;
   end

   // State register; reset always wins over any pending start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode plus the status outputs, which depend only on the
   // current state. start is looked at only in IDLE, so a held start simply
   // relaunches once the previous result has been presented.
   always_comb begin
      nextState = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (lastStep) begin
               nextState = FIX;
            end
         end
         FIX: begin
            busy      = 1'b1;
            nextState = DONE;
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath. Operands are captured as magnitudes at the start edge so later
   // input changes cannot disturb the running multiply. Each CALC cycle adds
   // the shifted multiplicand when the current multiplier bit is set. The
   // result registers are written only in FIX, so they hold the previous
   // product for the whole of the next operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         accum     <= '0;
         mcand     <= '0;
         mplier    <= '0;
         count     <= '0;
         negResult <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand     <= {{WIDTH{1'b0}}, absA};
                  mplier    <= absB;
                  negResult <= (a[WIDTH-1] ^ b[WIDTH-1]) & is_signed;
                  accum     <= '0;
                  count     <= '0;
               end
            end
            CALC: begin
               if (mplier[0]) begin
                  accum <= accum + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
            end
            FIX: begin
               result_lo <= product[WIDTH-1:0];
               result_hi <= product[2*WIDTH-1:WIDTH];
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq (WIDTH=32): stimulus queues expected products,
// a negedge monitor pops and compares whenever done is presented.
module tb_mul_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic        isSigned;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] resultLo;
   logic [31:0] resultHi;

   logic [63:0] expQ[$];
   logic [63:0] prevResult;
   int          vecCount;
   int          errCount;
   int          doneCount;

   mul_seq #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .is_signed(isSigned),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .result_lo(resultLo),
      .result_hi(resultHi)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global bound so the run always ends even if the DUT locks up.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done cycle must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         doneCount++;
         if (expQ.size() == 0) begin
            vecCount++;
            errCount++;
            $display("[TB] FAIL unexpectedDone: got done=1, expected no pending result");
         end else begin
            checkOutput("product", {resultHi, resultLo}, expQ.pop_front());
         end
      end
   end

   // Launch one multiply, scramble the inputs after capture, and time the
   // busy window and done latency relative to the capture edge.
   task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb,
                                input logic ts, input logic [63:0] exp);
      int edges;
      int busyCycles;
      bit seen;
      @(negedge clk);
      a        = ta;
      b        = tb;
      isSigned = ts;
      start    = 1'b1;
      expQ.push_back(exp);
      @(posedge clk);
      #1;
      start      = 1'b0;
      a          = ~ta;
      b          = $urandom;
      isSigned   = ~ts;
      busyCycles = busy ? 1 : 0;
      edges      = 0;
      seen       = 1'b0;
      while (!seen && edges < 60) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 10) begin
            checkOutput("holdDuringCalc", {resultHi, resultLo}, prevResult);
         end
         if (done) begin
            seen = 1'b1;
         end else if (busy) begin
            busyCycles++;
         end
      end
      checkOutput("doneLatency", 64'(edges), 64'd33);
      checkOutput("busyCycles", 64'(busyCycles), 64'd33);
      @(posedge clk);
      #1;
      checkOutput("donePulseEnd", {62'd0, busy, done}, 64'd0);
      prevResult = exp;
   endtask

   // Directed sequence covering reset, signed/unsigned corners, input
   // isolation, abort, reset priority and back-to-back launches.
   initial begin
      int dc0;
      int lastDone;
      int nDone;
      int lowRun;
      bit seenHigh;
      bit prevBusy;

      vecCount   = 0;
      errCount   = 0;
      doneCount  = 0;
      prevResult = 64'd0;
      reset      = 1'b1;
      start      = 1'b0;
      isSigned   = 1'b0;
      a          = 32'd0;
      b          = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetResult", {resultHi, resultLo}, 64'd0);
      checkOutput("resetStatus", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF);
      applyStimulus(32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
      applyStimulus(32'h1234_5678, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000);
      applyStimulus(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);

      // Inputs and start toggled during CALC must be ignored.
      dc0 = doneCount;
      @(negedge clk);
      a        = 32'd7;
      b        = 32'd6;
      isSigned = 1'b0;
      start    = 1'b1;
      expQ.push_back(64'd42);
      @(posedge clk);
      #1;
      a        = 32'd0;
      b        = 32'd0;
      isSigned = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      start = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      checkOutput("ignoreDoneCount", 64'(doneCount - dc0), 64'd1);
      prevResult = 64'd42;

      // Abort in the 10th CALC cycle.
      @(negedge clk);
      a     = 32'd5;
      b     = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abortStatus", {62'd0, busy, done}, 64'd0);
      checkOutput("abortResult", {resultHi, resultLo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      dc0   = doneCount;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("abortNoDone", 64'(doneCount - dc0), 64'd0);
      prevResult = 64'd0;
      applyStimulus(32'd3, 32'd5, 1'b0, 64'd15);

      // Reset and start together: nothing starts.
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      a     = 32'd3;
      b     = 32'd3;
      @(posedge clk);
      #1;
      checkOutput("resetPriorityBusy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("resetPriorityIdle", {63'd0, busy}, 64'd0);
      prevResult = 64'd0;

      // Back-to-back with start held high.
      @(negedge clk);
      a        = 32'd2;
      b        = 32'd3;
      isSigned = 1'b0;
      start    = 1'b1;
      lastDone = -1;
      nDone    = 0;
      lowRun   = 0;
      seenHigh = 1'b0;
      prevBusy = 1'b0;
      for (int t = 1; t <= 110; t++) begin
         @(posedge clk);
         #1;
         if (busy && !prevBusy) begin
            expQ.push_back(64'd6);
         end
         prevBusy = busy;
         if (done) begin
            nDone++;
            if (lastDone >= 0) begin
               checkOutput("doneSpacing", 64'(t - lastDone), 64'd35);
            end
            lastDone = t;
         end
         if (busy) begin
            if (seenHigh) begin
               if (lowRun > 0) begin
                  checkOutput("idleGap", 64'(lowRun), 64'd2);
               end
            end
            seenHigh = 1'b1;
            lowRun   = 0;
         end else begin
            lowRun++;
         end
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("backToBackDones", 64'(nDone), 64'd3);
      repeat (45) @(posedge clk);
      #1;
      checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
      checkOutput("finalIdle", {62'd0, busy, done}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
